// File: rtl/alu_exec_unit_if.sv
// Issue / CDB bundle for the ALU execution unit.
// master: reservation station + CDB arbiter side; slave: the execution unit.
interface alu_exec_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
);
  logic             flush;
  logic             issue_valid;
  logic             issue_ready;
  logic [3:0]       issue_alu_ctrl;
  logic [XLEN-1:0]  issue_src1;
  logic [XLEN-1:0]  issue_src2;
  logic [TAG_W-1:0] issue_tag;
  logic             cdb_valid;
  logic             cdb_grant;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_result;
  logic             cdb_exc;
  logic             busy;

  modport master (
    output flush, issue_valid, issue_alu_ctrl, issue_src1, issue_src2, issue_tag, cdb_grant,
    input  issue_ready, cdb_valid, cdb_tag, cdb_result, cdb_exc, busy
  );

  modport slave (
    input  flush, issue_valid, issue_alu_ctrl, issue_src1, issue_src2, issue_tag, cdb_grant,
    output issue_ready, cdb_valid, cdb_tag, cdb_result, cdb_exc, busy
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Integer execution unit: one op per cycle from the ALU reservation station,
// registered into E1, evaluated combinationally there, queued in a small
// result FIFO and broadcast on the CDB under a valid/grant handshake.
//
// Optional feature macro ALU_EXC_EN: when defined, illegal ALUControl codes
// raise cdb_exc alongside a zero result and the flag is stored per FIFO entry.
// When undefined, cdb_exc is tied low and no flag storage exists.
//
// No FSM here: control is an E1 valid bit plus FIFO pointers/count.
module alu_exec_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6,
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  alu_exec_unit_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam int SH_W  = $clog2(XLEN);

  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_LUI = 4'b1000;

  // E1 stage registers
  logic             e1_valid_q, e1_valid_d;
  logic [3:0]       e1_ctrl_q,  e1_ctrl_d;
  logic [XLEN-1:0]  e1_a_q,     e1_a_d;
  logic [XLEN-1:0]  e1_b_q,     e1_b_d;
  logic [TAG_W-1:0] e1_tag_q,   e1_tag_d;

  // Result FIFO storage and bookkeeping
  logic [XLEN-1:0]  res_mem_q [DEPTH];
  logic [TAG_W-1:0] tag_mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  // Handshake and datapath wires
  logic [OCC_W-1:0] occupancy;
  logic             issue_ready;
  logic             accept;
  logic             fifo_nonempty;
  logic             fifo_full;
  logic             cdb_valid;
  logic             pop;
  logic             push;
  logic [XLEN-1:0]  e1_result;

  // Occupancy counts the E1 slot too, so an accepted op always has a FIFO
  // slot waiting for it one cycle later and E1 never has to stall.
  assign occupancy     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, e1_valid_q};
  assign issue_ready   = !rst && !bus.flush && (occupancy < OCC_W'(DEPTH));
  assign accept        = bus.issue_valid && issue_ready;
  assign fifo_nonempty = (cnt_q != '0);
  assign fifo_full     = (cnt_q == CNT_W'(DEPTH));
  assign cdb_valid     = !rst && fifo_nonempty;
  // A grant during flush is ignored; the whole queue is dropped instead.
  assign pop           = cdb_valid && bus.cdb_grant && !bus.flush;
  // Push is guarded against a full FIFO without a pop for robustness, even
  // though the occupancy rule above keeps that case unreachable.
  assign push          = !rst && !bus.flush && e1_valid_q && (!fifo_full || pop);

  // E1 ALU: combinational result from the E1 registers
  always_comb begin
    e1_result = '0;
    case (e1_ctrl_q)
      OP_ADD:  e1_result = e1_a_q + e1_b_q;
      OP_SUB:  e1_result = e1_a_q - e1_b_q;
      OP_XOR:  e1_result = e1_a_q ^ e1_b_q;
      OP_OR:   e1_result = e1_a_q | e1_b_q;
      OP_SRA:  e1_result = $signed(e1_a_q) >>> e1_b_q[SH_W-1:0];
      OP_LUI:  e1_result = e1_b_q;
      default: e1_result = '0;
    endcase
  end

`ifdef ALU_EXC_EN
  logic e1_illegal;
  logic exc_mem_q [DEPTH];

  // Illegal-code detection for the per-entry exception flag
  always_comb begin
    e1_illegal = 1'b1;
    case (e1_ctrl_q)
      OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_SRA, OP_LUI: e1_illegal = 1'b0;
      default:                                       e1_illegal = 1'b1;
    endcase
  end

  // Exception flag storage, written alongside the result
  always_ff @(posedge clk) begin
    if (push) begin
      exc_mem_q[wr_ptr_q] <= e1_illegal;
    end
  end
`endif

  // E1 next state: load on accept, drain into the FIFO, clear on flush
  always_comb begin
    e1_valid_d = e1_valid_q && !push;
    e1_ctrl_d  = e1_ctrl_q;
    e1_a_d     = e1_a_q;
    e1_b_d     = e1_b_q;
    e1_tag_d   = e1_tag_q;
    if (accept) begin
      e1_valid_d = 1'b1;
      e1_ctrl_d  = bus.issue_alu_ctrl;
      e1_a_d     = bus.issue_src1;
      e1_b_d     = bus.issue_src2;
      e1_tag_d   = bus.issue_tag;
    end
    if (bus.flush) begin
      e1_valid_d = 1'b0;
    end
  end

  // E1 state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      e1_valid_q <= 1'b0;
      e1_ctrl_q  <= '0;
      e1_a_q     <= '0;
      e1_b_q     <= '0;
      e1_tag_q   <= '0;
    end else begin
      e1_valid_q <= e1_valid_d;
      e1_ctrl_q  <= e1_ctrl_d;
      e1_a_q     <= e1_a_d;
      e1_b_q     <= e1_b_d;
      e1_tag_q   <= e1_tag_d;
    end
  end

  // FIFO pointer/count next state; pointers wrap because DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  // FIFO pointer/count registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // FIFO payload storage; contents are only visible through a valid head
  always_ff @(posedge clk) begin
    if (push) begin
      res_mem_q[wr_ptr_q] <= e1_result;
      tag_mem_q[wr_ptr_q] <= e1_tag_q;
    end
  end

  // Outputs are forced to zero whenever the head is not valid (incl. reset)
  assign bus.issue_ready = issue_ready;
  assign bus.cdb_valid   = cdb_valid;
  assign bus.cdb_tag     = cdb_valid ? tag_mem_q[rd_ptr_q] : '0;
  assign bus.cdb_result  = cdb_valid ? res_mem_q[rd_ptr_q] : '0;
`ifdef ALU_EXC_EN
  assign bus.cdb_exc     = cdb_valid ? exc_mem_q[rd_ptr_q] : 1'b0;
`else
  assign bus.cdb_exc     = 1'b0;
`endif
  assign bus.busy        = !rst && (e1_valid_q || fifo_nonempty);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: queue-based reference model checked
// every cycle, plus directed literal checks on key scenarios and a random phase.
module tb_alu_exec_unit;
  localparam int XLEN  = 32;
  localparam int TAG_W = 6;
  localparam int DEPTH = 4;

`ifdef ALU_EXC_EN
  localparam bit EXC_ON = 1'b1;
`else
  localparam bit EXC_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_exec_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  alu_exec_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  res;
    logic             exc;
  } ent_t;

  ent_t e1q[$];
  ent_t fq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic ent_t ref_op(logic [3:0] c, logic [XLEN-1:0] a, logic [XLEN-1:0] b,
                                  logic [TAG_W-1:0] t);
    ent_t   e;
    longint sa;
    e.tag = t;
    e.exc = 1'b0;
    e.res = '0;
    case (c)
      4'b0010: e.res = a + b;
      4'b0110: e.res = a - b;
      4'b0011: e.res = a ^ b;
      4'b0001: e.res = a | b;
      4'b0111: begin
        sa    = longint'($signed(a));
        sa    = sa >>> int'(b[4:0]);
        e.res = sa[XLEN-1:0];
      end
      4'b1000: e.res = b;
      default: begin
        e.res = '0;
        e.exc = EXC_ON;
      end
    endcase
    return e;
  endfunction

  // Per-cycle compare of every output against the model, then model update on the edge
  initial begin
    ent_t h;
    bit   acc;
    forever begin
      @(negedge clk);
      h = '0;
      if (fq.size() > 0) h = fq[0];
      if (rst) begin
        chk("m_ready_rst", bus.issue_ready, 0);
        chk("m_valid_rst", bus.cdb_valid, 0);
        chk("m_tag_rst",   bus.cdb_tag, 0);
        chk("m_res_rst",   bus.cdb_result, 0);
        chk("m_exc_rst",   bus.cdb_exc, 0);
        chk("m_busy_rst",  bus.busy, 0);
      end else begin
        chk("m_ready", bus.issue_ready,
            64'((fq.size() + e1q.size() < DEPTH) && !bus.flush));
        chk("m_valid", bus.cdb_valid, 64'(fq.size() > 0));
        chk("m_tag",   bus.cdb_tag, 64'(h.tag));
        chk("m_res",   bus.cdb_result, 64'(h.res));
        chk("m_exc",   bus.cdb_exc, 64'(h.exc));
        chk("m_busy",  bus.busy, 64'(fq.size() + e1q.size() > 0));
      end
      @(posedge clk);
      acc = !rst && bus.issue_valid && !bus.flush && (fq.size() + e1q.size() < DEPTH);
      if (rst || bus.flush) begin
        fq.delete();
        e1q.delete();
      end else begin
        if (fq.size() > 0 && bus.cdb_grant) void'(fq.pop_front());
        if (e1q.size() > 0) fq.push_back(e1q.pop_front());
        if (acc) e1q.push_back(ref_op(bus.issue_alu_ctrl, bus.issue_src1, bus.issue_src2,
                                      bus.issue_tag));
      end
    end
  end

  task automatic drive(bit v, logic [3:0] c, logic [XLEN-1:0] a, logic [XLEN-1:0] b,
                       logic [TAG_W-1:0] t, bit g, bit f);
    bus.issue_valid    = v;
    bus.issue_alu_ctrl = c;
    bus.issue_src1     = a;
    bus.issue_src2     = b;
    bus.issue_tag      = t;
    bus.cdb_grant      = g;
    bus.flush          = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op into an idle unit and pin its result at N+2 with literal values
  task automatic op_lit(string nm, logic [3:0] c, logic [XLEN-1:0] a, logic [XLEN-1:0] b,
                        logic [TAG_W-1:0] t, logic [XLEN-1:0] exp_res, bit exp_exc);
    drive(1, c, a, b, t, 0, 0);
    @(negedge clk);
    chk({nm, "_ready"}, bus.issue_ready, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk({nm, "_n1_valid"}, bus.cdb_valid, 0);
    tick();
    @(negedge clk);
    chk({nm, "_n2_valid"}, bus.cdb_valid, 1);
    chk({nm, "_tag"}, bus.cdb_tag, 64'(t));
    chk({nm, "_res"}, bus.cdb_result, 64'(exp_res));
    chk({nm, "_exc"}, bus.cdb_exc, 64'(exp_exc));
    bus.cdb_grant = 1'b1;
    tick();
    bus.cdb_grant = 1'b0;
    @(negedge clk);
    chk({nm, "_popped"}, bus.cdb_valid, 0);
    tick();
  endtask

  // Fill the unit with 4 ops under no grant: 3 end up queued, 1 left in E1
  task automatic fill4(logic [TAG_W-1:0] base);
    for (int i = 0; i < 4; i++) begin
      drive(1, 4'b0010, XLEN'(i), XLEN'(100), base + TAG_W'(i), 0, 0);
      tick();
    end
  endtask

  initial begin
    int bp_acc;
    logic [3:0] codes [8];
    codes[0] = 4'b0010; codes[1] = 4'b0110; codes[2] = 4'b0011; codes[3] = 4'b0001;
    codes[4] = 4'b0111; codes[5] = 4'b1000; codes[6] = 4'b1111; codes[7] = 4'b0000;

    // Reset held 3 cycles with an op presented
    rst = 1'b1;
    drive(1, 4'b0010, 32'd1, 32'd2, 6'd9, 1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ready", bus.issue_ready, 0);
      chk("rst_valid", bus.cdb_valid, 0);
      tick();
    end
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("post_rst_ready", bus.issue_ready, 1);
    chk("post_rst_busy", bus.busy, 0);
    tick();

    // Directed ops with literal results
    op_lit("add", 4'b0010, 32'h7FFF_FFFF, 32'h1,         6'd1,  32'h8000_0000, 0);
    op_lit("sub", 4'b0110, 32'd5,         32'd7,         6'd2,  32'hFFFF_FFFE, 0);
    op_lit("sra", 4'b0111, 32'h8000_0000, 32'h21,        6'd3,  32'hC000_0000, 0);
    op_lit("lui", 4'b1000, 32'hDEAD_BEEF, 32'h1234_5000, 6'd4,  32'h1234_5000, 0);
    op_lit("xor", 4'b0011, 32'hF0F0_00FF, 32'h0FF0_0F0F, 6'd5,  32'hFF00_0FF0, 0);
    op_lit("or",  4'b0001, 32'h0000_1200, 32'h0034_0000, 6'd6,  32'h0034_1200, 0);
    op_lit("ill", 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 6'h2A, 32'h0,         EXC_ON);

    // Back-pressure: 6 issue attempts with no grant
    bp_acc = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 4'b0010, XLEN'(i), 32'd0, 6'd10 + 6'(i), 0, 0);
      @(negedge clk);
      if (bus.issue_valid && bus.issue_ready) bp_acc++;
      tick();
    end
    drive(0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    chk("bp_accepted", 64'(bp_acc), 4);
    chk("bp_ready_low", bus.issue_ready, 0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_drain_valid", bus.cdb_valid, 1);
      chk("bp_drain_tag", bus.cdb_tag, 64'(10 + k));
      chk("bp_drain_res", bus.cdb_result, 64'(k));
      tick();
    end
    @(negedge clk);
    chk("bp_empty", bus.cdb_valid, 0);
    tick();

    // Full E1+FIFO with grant and a new issue presented
    fill4(6'd20);
    drive(1, 4'b0010, 32'd7, 32'd7, 6'd24, 1, 0);
    @(negedge clk);
    chk("full_ready", bus.issue_ready, 0);
    chk("full_head", bus.cdb_tag, 20);
    tick();
    drive(0, 0, 0, 0, 0, 1, 0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk("full_drain_tag", bus.cdb_tag, 64'(20 + k));
      tick();
    end
    @(negedge clk);
    chk("full_no_dup", bus.cdb_valid, 0);
    tick();

    // Flush with 3 queued, 1 in E1 and an op presented
    fill4(6'd30);
    drive(1, 4'b0010, 32'd1, 32'd1, 6'd34, 1, 1);
    @(negedge clk);
    chk("flush_ready", bus.issue_ready, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("flush_valid", bus.cdb_valid, 0);
    chk("flush_busy", bus.busy, 0);
    tick();
    op_lit("post_flush", 4'b0010, 32'd2, 32'd3, 6'd35, 32'd5, 0);

    // Randomised phase with occasional flush and reset
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 3) != 0, codes[$urandom_range(0, 7)], $urandom, $urandom,
            TAG_W'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 1, 0);
    repeat (8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

endmodule
